// File: rtl/moldudp64_splitter.sv
// MoldUDP64 datagram splitter.
// Parses a MoldUDP64 payload byte stream (session, sequence, count, then
// length-prefixed messages) and forwards message bodies with framing flags,
// per-message sequence numbers, and datagram-level good/error counters.
//
// Ports:
//   clock, reset_n      - clock; asynchronous active-low reset (release synchronized)
//   data_in/valid_in    - payload byte and qualifier (no backpressure)
//   last_in             - final payload byte of the datagram (with valid_in)
//   msg_data_out        - forwarded body byte (0 when not forwarding)
//   msg_valid_out       - msg_data_out qualifier
//   msg_first_out       - first body byte of a message
//   msg_last_out        - final body byte of a message, or truncation point
//   msg_error_out       - message truncated by an early last_in
//   msg_seq_out         - sequence number of the message being forwarded
//   session_out         - session field of the most recent complete header
//   pkt_count_out       - datagrams parsed without error (wraps)
//   err_count_out       - malformed datagrams (saturates)
//   end_session_out     - one-cycle pulse when a header carries count 0xFFFF
module moldudp64_splitter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    input  logic        last_in,
    output logic [7:0]  msg_data_out,
    output logic        msg_valid_out,
    output logic        msg_first_out,
    output logic        msg_last_out,
    output logic        msg_error_out,
    output logic [63:0] msg_seq_out,
    output logic [79:0] session_out,
    output logic [31:0] pkt_count_out,
    output logic [15:0] err_count_out,
    output logic        end_session_out
);

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned SEQ_W     = 64;
    localparam int unsigned SESS_W    = 80;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PKT_W     = 32;
    localparam int unsigned ERR_W     = 16;
    localparam int unsigned HDR_BYTES = 20;
    localparam int unsigned HDR_W     = HDR_BYTES * BYTE_W;
    localparam int unsigned HBUF_W    = HDR_W - BYTE_W;
    localparam int unsigned HCNT_W    = 5;

    typedef enum logic [2:0] {
        S_HDR,
        S_LEN_HI,
        S_LEN_LO,
        S_BODY,
        S_DRAIN
    } state_t;

    // Reset synchronizer: asserts asynchronously, releases on clock.
    logic [1:0] rst_pipe;
    logic       rst_n_int;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n_int = rst_pipe[1];

    state_t              state_q, state_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [HBUF_W-1:0]   hdr_q, hdr_d;
    logic [BYTE_W-1:0]   len_hi_q, len_hi_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    body_cnt_q, body_cnt_d;
    logic [CNT_W-1:0]    msgs_left_q, msgs_left_d;
    logic [SEQ_W-1:0]    cur_seq_q, cur_seq_d;

    logic [BYTE_W-1:0]   data_d;
    logic                valid_d, first_d, last_d, error_d, end_d;
    logic [SEQ_W-1:0]    seq_d;
    logic [SESS_W-1:0]   session_d;
    logic [PKT_W-1:0]    pkt_d;
    logic [ERR_W-1:0]    err_d;

    logic                pkt_inc, err_inc;
    logic [HDR_W-1:0]    hdr_full;
    logic [CNT_W-1:0]    hdr_count;
    logic [CNT_W-1:0]    msg_len;
    logic                body_done, last_msg;

    assign hdr_full  = {hdr_q, data_in};
    assign hdr_count = hdr_full[CNT_W-1:0];
    assign msg_len   = {len_hi_q, data_in};
    assign body_done = (body_cnt_q == len_q);
    assign last_msg  = (msgs_left_q == CNT_W'(1));

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        hdr_d       = hdr_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        body_cnt_d  = body_cnt_q;
        msgs_left_d = msgs_left_q;
        cur_seq_d   = cur_seq_q;
        data_d      = '0;
        valid_d     = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        error_d     = 1'b0;
        end_d       = 1'b0;
        seq_d       = msg_seq_out;
        session_d   = session_out;
        pkt_d       = pkt_count_out;
        err_d       = err_count_out;
        pkt_inc     = 1'b0;
        err_inc     = 1'b0;

        if (valid_in) begin
            case (state_q)
                S_HDR: begin
                    hdr_d  = {hdr_q[HBUF_W-BYTE_W-1:0], data_in};
                    hcnt_d = hcnt_q + HCNT_W'(1);
                    if (hcnt_q == HCNT_W'(HDR_BYTES - 1)) begin
                        hcnt_d      = '0;
                        session_d   = hdr_full[HDR_W-1 -: SESS_W];
                        cur_seq_d   = hdr_full[CNT_W +: SEQ_W];
                        msgs_left_d = hdr_count;
                        end_d       = (hdr_count == '1);
                        // Heartbeat and end-of-session headers carry no messages.
                        if (hdr_count == '0 || hdr_count == '1) begin
                            state_d = S_DRAIN;
                            pkt_inc = last_in;
                        end else begin
                            state_d = S_LEN_HI;
                            err_inc = last_in;
                        end
                    end else begin
                        err_inc = last_in;
                    end
                end
                S_LEN_HI: begin
                    len_hi_d = data_in;
                    state_d  = S_LEN_LO;
                    err_inc  = last_in;
                end
                S_LEN_LO: begin
                    len_d      = msg_len;
                    body_cnt_d = CNT_W'(1);
                    if (msg_len == '0) begin
                        // Empty message: consumes a sequence number, emits nothing.
                        cur_seq_d   = cur_seq_q + SEQ_W'(1);
                        msgs_left_d = msgs_left_q - CNT_W'(1);
                        state_d     = last_msg ? S_DRAIN : S_LEN_HI;
                        pkt_inc     = last_in && last_msg;
                        err_inc     = last_in && !last_msg;
                    end else begin
                        state_d = S_BODY;
                        err_inc = last_in;
                    end
                end
                S_BODY: begin
                    valid_d = 1'b1;
                    data_d  = data_in;
                    first_d = (body_cnt_q == CNT_W'(1));
                    seq_d   = cur_seq_q;
                    last_d  = body_done || last_in;
                    error_d = last_in && !(body_done && last_msg);
                    pkt_inc = last_in && body_done && last_msg;
                    err_inc = error_d;
                    if (body_done) begin
                        cur_seq_d   = cur_seq_q + SEQ_W'(1);
                        msgs_left_d = msgs_left_q - CNT_W'(1);
                        state_d     = last_msg ? S_DRAIN : S_LEN_HI;
                    end else begin
                        body_cnt_d = body_cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Any byte here is past the declared content.
                    err_inc = last_in;
                end
                default: state_d = S_HDR;
            endcase

            if (last_in) begin
                state_d = S_HDR;
                hcnt_d  = '0;
            end
            if (pkt_inc) pkt_d = pkt_count_out + PKT_W'(1);
            if (err_inc && err_count_out != '1) err_d = err_count_out + ERR_W'(1);
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q         <= S_HDR;
            hcnt_q          <= '0;
            hdr_q           <= '0;
            len_hi_q        <= '0;
            len_q           <= '0;
            body_cnt_q      <= '0;
            msgs_left_q     <= '0;
            cur_seq_q       <= '0;
            msg_data_out    <= '0;
            msg_valid_out   <= 1'b0;
            msg_first_out   <= 1'b0;
            msg_last_out    <= 1'b0;
            msg_error_out   <= 1'b0;
            msg_seq_out     <= '0;
            session_out     <= '0;
            pkt_count_out   <= '0;
            err_count_out   <= '0;
            end_session_out <= 1'b0;
        end else begin
            state_q         <= state_d;
            hcnt_q          <= hcnt_d;
            hdr_q           <= hdr_d;
            len_hi_q        <= len_hi_d;
            len_q           <= len_d;
            body_cnt_q      <= body_cnt_d;
            msgs_left_q     <= msgs_left_d;
            cur_seq_q       <= cur_seq_d;
            msg_data_out    <= data_d;
            msg_valid_out   <= valid_d;
            msg_first_out   <= first_d;
            msg_last_out    <= last_d;
            msg_error_out   <= error_d;
            msg_seq_out     <= seq_d;
            session_out     <= session_d;
            pkt_count_out   <= pkt_d;
            err_count_out   <= err_d;
            end_session_out <= end_d;
        end
    end

endmodule

// File: tb/tb_moldudp64_splitter.sv
// Self-checking bench for moldudp64_splitter.
// Datagrams are built from a message-level description; expected body bytes,
// flags, sequence numbers and counter effects are derived from that
// description, then compared with what the DUT emits.
module tb_moldudp64_splitter;

    logic        clock;
    logic        reset_n;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        last_in;
    logic [7:0]  msg_data_out;
    logic        msg_valid_out;
    logic        msg_first_out;
    logic        msg_last_out;
    logic        msg_error_out;
    logic [63:0] msg_seq_out;
    logic [79:0] session_out;
    logic [31:0] pkt_count_out;
    logic [15:0] err_count_out;
    logic        end_session_out;

    moldudp64_splitter dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .data_in         (data_in),
        .valid_in        (valid_in),
        .last_in         (last_in),
        .msg_data_out    (msg_data_out),
        .msg_valid_out   (msg_valid_out),
        .msg_first_out   (msg_first_out),
        .msg_last_out    (msg_last_out),
        .msg_error_out   (msg_error_out),
        .msg_seq_out     (msg_seq_out),
        .session_out     (session_out),
        .pkt_count_out   (pkt_count_out),
        .err_count_out   (err_count_out),
        .end_session_out (end_session_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  d;
        logic        f;
        logic        l;
        logic        e;
        logic [63:0] s;
    } rec_t;

    rec_t       act_q[$];
    rec_t       exp_q[$];
    rec_t       ref_q[$];
    logic [7:0] stream_q[$];
    logic [7:0] body_q[$];
    int         lens_q[$];

    int total = 0;
    int bad   = 0;
    int idle_bad = 0;
    int end_cnt  = 0;

    logic [31:0] exp_pkt;
    logic [15:0] exp_err;
    logic [79:0] exp_session;
    bit          pend_pkt, pend_err, pend_hdr, pend_end;
    logic [79:0] pend_sess;

    // Output monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (msg_valid_out)
            act_q.push_back({msg_data_out, msg_first_out, msg_last_out, msg_error_out, msg_seq_out});
        else if (msg_first_out || msg_last_out || msg_error_out || msg_data_out != 8'h00)
            idle_bad++;
        if (end_session_out) end_cnt++;
    end

    // Build the byte stream and expectations for one datagram from lens_q/body_q.
    // trunc >= 0 puts last_in on that byte index; extra appends overrun bytes.
    task automatic build(input logic [79:0] sess, input logic [63:0] seq,
                         input logic [15:0] cnt, input int extra, input int trunc);
        logic [159:0] hdr;
        logic [15:0]  len;
        int           pos_q[$];
        rec_t         cand_q[$];
        rec_t         r;
        int           b;
        int           final_i;
        int           good_end;
        stream_q.delete();
        exp_q.delete();
        hdr = {sess, seq, cnt};
        b = 0;
        for (int i = 0; i < 20; i++) stream_q.push_back(hdr[159-8*i -: 8]);
        for (int k = 0; k < lens_q.size(); k++) begin
            len = 16'(lens_q[k]);
            stream_q.push_back(len[15:8]);
            stream_q.push_back(len[7:0]);
            for (int j = 0; j < lens_q[k]; j++) begin
                pos_q.push_back(stream_q.size());
                cand_q.push_back({body_q[b], j == 0, j == lens_q[k] - 1, 1'b0, seq + 64'(k)});
                stream_q.push_back(body_q[b]);
                b++;
            end
        end
        good_end = stream_q.size() - 1;
        for (int i = 0; i < extra; i++) stream_q.push_back(8'($urandom));
        final_i = (trunc >= 0) ? trunc : stream_q.size() - 1;
        while (stream_q.size() > final_i + 1) void'(stream_q.pop_back());
        pend_pkt  = (final_i == good_end);
        pend_err  = !pend_pkt;
        pend_hdr  = (final_i >= 19);
        pend_end  = pend_hdr && (cnt == 16'hFFFF);
        pend_sess = sess;
        for (int i = 0; i < cand_q.size(); i++) begin
            if (pos_q[i] <= final_i) begin
                r = cand_q[i];
                if (pos_q[i] == final_i) begin
                    r.l = 1'b1;
                    r.e = !pend_pkt;
                end
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic commit();
        if (pend_pkt) exp_pkt = exp_pkt + 32'd1;
        if (pend_err && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        if (pend_hdr) exp_session = pend_sess;
    endtask

    task automatic rand_msgs(input int n);
        int len;
        lens_q.delete();
        body_q.delete();
        for (int k = 0; k < n; k++) begin
            len = (k == n - 1) ? int'($urandom_range(1, 6)) : int'($urandom_range(0, 5));
            lens_q.push_back(len);
            for (int j = 0; j < len; j++) body_q.push_back(8'($urandom));
        end
    endtask

    // Drive the first n bytes of stream_q; gaps insert an idle cycle (with junk
    // data and last_in high) after every other byte.
    task automatic drive_stream(input int n, input bit gaps);
        @(posedge clock);
        act_q.delete();
        end_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            valid_in = 1'b1;
            data_in  = stream_q[i];
            last_in  = (i == stream_q.size() - 1);
            if (gaps && (i % 2 == 1)) begin
                @(negedge clock);
                valid_in = 1'b0;
                data_in  = 8'($urandom);
                last_in  = 1'b1;
            end
        end
        @(negedge clock);
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = 8'h00;
        exp_pkt = '0; exp_err = '0; exp_session = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({msg_valid_out, msg_first_out, msg_last_out, msg_error_out, msg_data_out, end_session_out} !== 13'h0) begin
            bad++; $display("FAIL reset_msg got=%b want=0", {msg_valid_out, msg_first_out, msg_last_out, msg_error_out, msg_data_out, end_session_out});
        end
        total++;
        if (msg_seq_out !== 64'h0) begin bad++; $display("FAIL reset_seq got=%h want=0", msg_seq_out); end
        total++;
        if (session_out !== 80'h0) begin bad++; $display("FAIL reset_session got=%h want=0", session_out); end
        total++;
        if ({pkt_count_out, err_count_out} !== 48'h0) begin
            bad++; $display("FAIL reset_counts got=%h/%h want=0/0", pkt_count_out, err_count_out);
        end
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_basic();
        lens_q = '{3, 1};
        body_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build({$urandom, $urandom, 16'h1234}, 64'h10, 16'd2, 0, -1);
        drive_stream(stream_q.size(), 1'b0);
        commit();
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL basic_len got=%0d want=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_out[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        total++;
        if (act_q.size() > 0 && act_q[0] !== {8'hAA, 1'b1, 1'b0, 1'b0, 64'h10}) begin
            bad++; $display("FAIL basic_first got=%h want=%h", act_q[0], {8'hAA, 1'b1, 1'b0, 1'b0, 64'h10});
        end
        total++;
        if (act_q.size() > 3 && act_q[3] !== {8'hDD, 1'b1, 1'b1, 1'b0, 64'h11}) begin
            bad++; $display("FAIL basic_dd got=%h want=%h", act_q[3], {8'hDD, 1'b1, 1'b1, 1'b0, 64'h11});
        end
        total++;
        if (pkt_count_out !== 32'd1) begin bad++; $display("FAIL basic_pkt got=%0d want=1", pkt_count_out); end
        total++;
        if (err_count_out !== exp_err) begin bad++; $display("FAIL basic_err got=%0d want=%0d", err_count_out, exp_err); end
    endtask

    task automatic test_heartbeat();
        logic [79:0] sess;
        sess = {$urandom, $urandom, $urandom};
        lens_q.delete();
        body_q.delete();
        build(sess, {$urandom, $urandom}, 16'd0, 0, -1);
        drive_stream(stream_q.size(), 1'b0);
        commit();
        total++;
        if (act_q.size() !== 0) begin bad++; $display("FAIL hb_out got=%0d want=0", act_q.size()); end
        total++;
        if (pkt_count_out !== exp_pkt) begin bad++; $display("FAIL hb_pkt got=%0d want=%0d", pkt_count_out, exp_pkt); end
        total++;
        if (session_out !== sess) begin bad++; $display("FAIL hb_session got=%h want=%h", session_out, sess); end
        total++;
        if (end_cnt !== 0) begin bad++; $display("FAIL hb_end got=%0d want=0", end_cnt); end
    endtask

    task automatic test_truncation();
        lens_q = '{5};
        body_q.delete();
        for (int j = 0; j < 5; j++) body_q.push_back(8'($urandom));
        build({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 16'd1, 0, 24);
        drive_stream(stream_q.size(), 1'b0);
        commit();
        total++;
        if (act_q.size() !== 3) begin bad++; $display("FAIL trunc_len got=%0d want=3", act_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL trunc_out[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        total++;
        if (act_q.size() > 2 && {act_q[2].l, act_q[2].e} !== 2'b11) begin
            bad++; $display("FAIL trunc_flags got=%b want=11", {act_q[2].l, act_q[2].e});
        end
        total++;
        if (err_count_out !== 16'd1) begin bad++; $display("FAIL trunc_err got=%0d want=1", err_count_out); end
        rand_msgs(2);
        build({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 16'd2, 0, -1);
        drive_stream(stream_q.size(), 1'b0);
        commit();
        total++;
        if (act_q !== exp_q) begin bad++; $display("FAIL trunc_next got=%0d bytes want=%0d", act_q.size(), exp_q.size()); end
        total++;
        if (pkt_count_out !== exp_pkt) begin bad++; $display("FAIL trunc_next_pkt got=%0d want=%0d", pkt_count_out, exp_pkt); end
    endtask

    task automatic test_overrun();
        lens_q = '{2};
        body_q = '{8'h5A, 8'hA5};
        build({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 16'd1, 4, -1);
        drive_stream(stream_q.size(), 1'b0);
        commit();
        total++;
        if (act_q !== exp_q) begin bad++; $display("FAIL ovr_out got=%0d bytes want=%0d", act_q.size(), exp_q.size()); end
        total++;
        if (act_q.size() > 1 && {act_q[1].l, act_q[1].e} !== 2'b10) begin
            bad++; $display("FAIL ovr_flags got=%b want=10", {act_q[1].l, act_q[1].e});
        end
        total++;
        if (err_count_out !== exp_err) begin bad++; $display("FAIL ovr_err got=%0d want=%0d", err_count_out, exp_err); end
        total++;
        if (pkt_count_out !== exp_pkt) begin bad++; $display("FAIL ovr_pkt got=%0d want=%0d", pkt_count_out, exp_pkt); end
    endtask

    task automatic test_gaps();
        logic [79:0] sess;
        sess = {$urandom, $urandom, $urandom};
        rand_msgs(2);
        build(sess, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 0, -1);
        drive_stream(stream_q.size(), 1'b0);
        commit();
        ref_q = act_q;
        drive_stream(stream_q.size(), 1'b1);
        commit();
        total++;
        if (act_q !== ref_q) begin bad++; $display("FAIL gap_vs_nogap got=%0d bytes want=%0d", act_q.size(), ref_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL gap_out[%0d] got=%h want=%h", i, act_q[i], exp_q[i]); end
        end
        total++;
        if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL gap_len got=%0d want=%0d", act_q.size(), exp_q.size()); end
        total++;
        if (act_q.size() > 0 && act_q[act_q.size()-1].s !== 64'h0) begin
            bad++; $display("FAIL gap_wrap got=%h want=0", act_q[act_q.size()-1].s);
        end
        total++;
        if (pkt_count_out !== exp_pkt) begin bad++; $display("FAIL gap_pkt got=%0d want=%0d", pkt_count_out, exp_pkt); end
    endtask

    task automatic test_random();
        int n;
        int mode;
        int sz;
        logic [15:0] cnt;
        logic [63:0] seq;
        for (int it = 0; it < 16; it++) begin
            mode = it % 4;
            seq  = (it == 5) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
            if (mode == 3) begin
                lens_q.delete();
                body_q.delete();
                cnt = ($urandom % 2 == 0) ? 16'h0000 : 16'hFFFF;
                build({$urandom, $urandom, $urandom}, seq, cnt, int'($urandom_range(0, 2)), -1);
            end else begin
                n = int'($urandom_range(1, 4));
                rand_msgs(n);
                sz = 20;
                foreach (lens_q[k]) sz += 2 + lens_q[k];
                cnt = 16'(n);
                if (mode == 0)      build({$urandom, $urandom, $urandom}, seq, cnt, 0, -1);
                else if (mode == 1) build({$urandom, $urandom, $urandom}, seq, cnt, 0, int'($urandom_range(0, sz - 2)));
                else                build({$urandom, $urandom, $urandom}, seq, cnt, int'($urandom_range(1, 3)), -1);
            end
            drive_stream(stream_q.size(), 1'($urandom));
            commit();
            total++;
            if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_len got=%0d want=%0d", it, act_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
                total++;
                if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_out[%0d] got=%h want=%h", it, i, act_q[i], exp_q[i]); end
            end
            total++;
            if ({pkt_count_out, err_count_out} !== {exp_pkt, exp_err}) begin
                bad++; $display("FAIL rnd%0d_counts got=%0d/%0d want=%0d/%0d", it, pkt_count_out, err_count_out, exp_pkt, exp_err);
            end
            total++;
            if (session_out !== exp_session) begin bad++; $display("FAIL rnd%0d_session got=%h want=%h", it, session_out, exp_session); end
            total++;
            if (end_cnt !== int'(pend_end)) begin bad++; $display("FAIL rnd%0d_end got=%0d want=%0d", it, end_cnt, pend_end); end
        end
        total++;
        if (idle_bad !== 0) begin bad++; $display("FAIL idle_msg got=%0d want=0", idle_bad); end
    endtask

    task automatic test_reset_mid();
        logic [79:0] sess;
        rand_msgs(1);
        lens_q = '{6};
        body_q.delete();
        for (int j = 0; j < 6; j++) body_q.push_back(8'($urandom));
        build({$urandom, $urandom, $urandom}, {$urandom, $urandom}, 16'd1, 0, -1);
        drive_stream(24, 1'b0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({pkt_count_out, err_count_out, session_out} !== 128'h0) begin
            bad++; $display("FAIL rstmid_async got=%h/%h/%h want=0", pkt_count_out, err_count_out, session_out);
        end
        repeat (3) @(negedge clock);
        total++;
        if ({msg_valid_out, msg_first_out, msg_last_out, msg_error_out, msg_data_out, msg_seq_out, end_session_out} !== 77'h0) begin
            bad++; $display("FAIL rstmid_msg got=%b%b%b%b want=0", msg_valid_out, msg_first_out, msg_last_out, msg_error_out);
        end
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clock);
        exp_pkt = '0; exp_err = '0; exp_session = '0;
        sess = {$urandom, $urandom, $urandom};
        lens_q.delete();
        body_q.delete();
        build(sess, {$urandom, $urandom}, 16'hFFFF, 0, -1);
        drive_stream(stream_q.size(), 1'b0);
        commit();
        total++;
        if (end_cnt !== 1) begin bad++; $display("FAIL rstmid_end got=%0d want=1", end_cnt); end
        total++;
        if (err_count_out !== 16'd0) begin bad++; $display("FAIL rstmid_err got=%0d want=0", err_count_out); end
        total++;
        if (pkt_count_out !== 32'd1) begin bad++; $display("FAIL rstmid_pkt got=%0d want=1", pkt_count_out); end
        total++;
        if (session_out !== sess) begin bad++; $display("FAIL rstmid_session got=%h want=%h", session_out, sess); end
        total++;
        if (act_q.size() !== 0) begin bad++; $display("FAIL rstmid_out got=%0d want=0", act_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_heartbeat();
        test_truncation();
        test_overrun();
        test_gaps();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/moldudp64_splitter.md
MOLDUDP64_SPLITTER -- requirements
Module: moldudp64_splitter

Interface
REQ-001 clock  in  1  single clock; all logic on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 data_in  in  8  UDP payload byte from the UDP/IP receive stage.
REQ-004 valid_in  in  1  data_in qualifier; no backpressure, so every valid byte is consumed.
REQ-005 last_in  in  1  final payload byte of the datagram; meaningful only with valid_in.
REQ-006 msg_data_out  out  8  message body byte.
REQ-007 msg_valid_out  out  1  msg_data_out qualifier.
REQ-008 msg_first_out  out  1  first body byte of a message.
REQ-009 msg_last_out  out  1  final body byte of a message, or the truncation point.
REQ-010 msg_error_out  out  1  accompanies msg_last_out when the message is truncated.
REQ-011 msg_seq_out  out  64  sequence number of the current message; held stable from msg_first_out through msg_last_out.
REQ-012 session_out  out  80  session field of the most recent good header.
REQ-013 pkt_count_out  out  32  datagrams fully parsed without error; wraps.
REQ-014 err_count_out  out  16  malformed datagrams; saturates at 0xFFFF.
REQ-015 end_session_out  out  1  one-cycle pulse when a header carries count 0xFFFF.

Function
REQ-016 Datagram layout is big-endian: session (10 B), sequence (8 B), count (2 B), then count messages; each message is a 2-byte length L followed by L body bytes.
REQ-017 The state machine has states HDR, LEN_HI, LEN_LO, BODY and DRAIN; state advances only on cycles with valid_in=1.
REQ-018 HDR consumes 20 bytes using a 5-bit byte counter; after byte 20, count=0 or count=0xFFFF goes to DRAIN, otherwise the state goes to LEN_HI.
REQ-019 LEN_HI captures L[15:8]; LEN_LO captures L[7:0]; L=0 skips to LEN_HI (or DRAIN if the message is the last one) with no output and a sequence increment; L>0 goes to BODY.
REQ-020 BODY forwards each byte with 1-cycle registered latency, asserting msg_first_out on body byte 1 and msg_last_out on body byte L.
REQ-021 After body byte L, the remaining-message counter decrements; at 0 the state goes to DRAIN, otherwise to LEN_HI.
REQ-022 The msg_seq_out of message k (0-based) is header sequence + k, computed modulo 2^64.
REQ-023 session_out and end_session_out update only after all 20 header bytes have been received.
REQ-024 In every state, last_in returns the state to HDR on the following cycle.
REQ-025 Good datagram: last_in on the final body byte of the final message, or on count byte 2 when count is 0 or 0xFFFF; on such a datagram pkt_count_out increments by 1.
REQ-026 Truncation: last_in arriving before the good-end position increments err_count_out once.
REQ-026a Truncation inside BODY additionally forces msg_last_out=1 and msg_error_out=1 on that byte.
REQ-027 Overrun: valid bytes received in DRAIN before last_in cause err_count_out to increment once, at last_in; these bytes are never forwarded.
REQ-028 The msg_* outputs are 0 on every cycle that does not forward a body byte.
REQ-029 Gaps in valid_in (valid_in=0) do not alter state, counters or outputs, except that the msg_* pulses return to 0.
REQ-030 When a message has L=1, msg_first_out and msg_last_out are asserted in the same cycle.

Reset
REQ-031 While reset_n=0, the state is HDR and all counters, the captured header, and every output are 0.
REQ-032 Reset asserted mid-datagram discards the partial datagram; after release, the next byte is treated as header byte 1, and the discarded datagram does not increment err_count_out.
REQ-033 Release of reset is synchronized to clock inside the block; assertion of reset remains asynchronous.

Verification
REQ-034 Scenario 1: header seq=0x10, count=2, messages L=3 (AA BB CC) and L=1 (DD), last_in on DD -> outputs AA(first, seq 0x10), BB, CC(last), DD(first+last, seq 0x11); pkt_count_out=1.
REQ-035 Scenario 2: heartbeat (count=0, 20 bytes, last_in on byte 20) -> no msg_valid_out; pkt_count_out increments; session_out updated.
REQ-036 Scenario 3: count=1, L=5, last_in on body byte 3 -> third output carries msg_last_out=1 and msg_error_out=1; err_count_out=1; the next datagram parses normally.
REQ-037 Scenario 4: count=1, L=2, then 4 extra bytes with last_in on the final extra byte -> the message is emitted cleanly; err_count_out increments at last_in; pkt_count_out is unchanged.
REQ-038 Scenario 5: seq=0xFFFF_FFFF_FFFF_FFFF, count=2, one valid_in=0 gap inserted every other byte -> seq values FFFF..FF then 0; output identical to the gap-free run.
REQ-039 Scenario 6: reset_n pulsed low during BODY, then a count=0xFFFF header -> all outputs read 0 during reset; end_session_out pulses once after the header; err_count_out=0.
